// File: rtl/maxnet_seq.sv
// maxnet_seq: iterative four-neuron MaxNet (winner-take-all) sequencer with start/busy/done handshake.
// Optional feature: define MAXNET_ABORT_EN to add an abort input that cancels a run in EVAL/UPDATE.
module maxnet_seq #(
  parameter int W         = 5,
  parameter int EPS_SHIFT = 3,
  parameter int MAX_ITER  = 63
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            start,
`ifdef MAXNET_ABORT_EN
  input  logic                            abort,
`endif
  input  logic [W-1:0]                    a0,
  input  logic [W-1:0]                    a1,
  input  logic [W-1:0]                    a2,
  input  logic [W-1:0]                    a3,
  output logic                            busy,
  output logic                            done,
  output logic [W-1:0]                    result,
  output logic [1:0]                      winner_idx,
  output logic                            none,
  output logic                            timeout,
  output logic [$clog2(MAX_ITER+1)-1:0]   iter_count
);

  localparam int IW = $clog2(MAX_ITER + 1);
  localparam int SW = W + 2;

  typedef enum logic [1:0] {IDLE, EVAL, UPDATE, DONE} state_t;

  state_t        state_q, state_d;
  logic [W-1:0]  r_q   [4];
  logic [W-1:0]  r_upd [4];
  logic [SW-1:0] sum;
  logic [SW-1:0] diff  [4];
  logic [SW-1:0] inhib [4];
  logic [2:0]    nz;
  logic [1:0]    one_idx, max_idx;
  logic          finish, abort_hit;

  // NOTE: every always_comb output gets a default before any branch, so no latch is inferred.
  always_comb begin
    sum = '0;
    for (int i = 0; i < 4; i++) sum = sum + SW'(r_q[i]);
  end

  // Lateral inhibition; a nonzero rival sum always removes at least 1 so the net keeps converging.
  always_comb begin
    for (int i = 0; i < 4; i++) begin
      diff[i]  = sum - SW'(r_q[i]);
      inhib[i] = diff[i] >> EPS_SHIFT;
      if (diff[i] != '0 && inhib[i] == '0) inhib[i] = SW'(1);
      r_upd[i] = (SW'(r_q[i]) > inhib[i]) ? r_q[i] - inhib[i][W-1:0] : '0;
    end
  end

  // Nonzero count, the sole survivor's index, and the largest value (lowest index wins ties).
  always_comb begin
    nz      = '0;
    one_idx = '0;
    max_idx = '0;
    for (int i = 0; i < 4; i++) begin
      if (r_q[i] != '0) begin
        nz      = nz + 3'd1;
        one_idx = 2'(i);
      end
      if (r_q[i] > r_q[max_idx]) max_idx = 2'(i);
    end
  end

  assign finish = (nz <= 3'd1) || (iter_count == IW'(MAX_ITER));

`ifdef MAXNET_ABORT_EN
  assign abort_hit = abort && (state_q == EVAL || state_q == UPDATE);
`else
  assign abort_hit = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (start) state_d = EVAL;
      EVAL:    state_d = finish ? DONE : UPDATE;
      UPDATE:  state_d = EVAL;
      DONE:    state_d = IDLE;
    endcase
    if (abort_hit) state_d = IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so all registers see pre-edge values.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      // NOTE: the activation array is only four small registers, so it is reset like any other state.
      for (int i = 0; i < 4; i++) r_q[i] <= '0;
      busy       <= 1'b0;
      result     <= '0;
      winner_idx <= '0;
      none       <= 1'b0;
      timeout    <= 1'b0;
      iter_count <= '0;
    end else if (abort_hit) begin
      busy    <= 1'b0;
      timeout <= 1'b1;
    end else begin
      unique case (state_q)
        IDLE: if (start) begin
          r_q[0]     <= a0;
          r_q[1]     <= a1;
          r_q[2]     <= a2;
          r_q[3]     <= a3;
          iter_count <= '0;
          none       <= 1'b0;
          timeout    <= 1'b0;
          busy       <= 1'b1;
        end
        EVAL: begin
          if (nz == 3'd1) begin
            result     <= r_q[one_idx];
            winner_idx <= one_idx;
          end else if (nz == 3'd0) begin
            none       <= 1'b1;
            result     <= '0;
            winner_idx <= '0;
          end else if (iter_count == IW'(MAX_ITER)) begin
            timeout    <= 1'b1;
            result     <= r_q[max_idx];
            winner_idx <= max_idx;
          end
        end
        UPDATE: begin
          for (int i = 0; i < 4; i++) r_q[i] <= r_upd[i];
          iter_count <= iter_count + IW'(1);
        end
        DONE: busy <= 1'b0;
      endcase
    end
  end

  assign done = (state_q == DONE);

endmodule
